// File: rtl/wb_sram_pkg.sv
// Shared definitions for the Wishbone / dual-port SRAM controller.
//   p0_state_e   : port-0 (Wishbone read/write) sequencer states
//   strm_state_e : port-1 streaming read engine states
//   RD_LAT       : posedges between driving an SRAM port and sampling its data
//   addr_hit()   : decodes a Wishbone byte address against the base window
package wb_sram_pkg;

    typedef enum logic [1:0] {
        P0_IDLE  = 2'd0,
        P0_ISSUE = 2'd1,
        P0_WAIT  = 2'd2,
        P0_ACK   = 2'd3
    } p0_state_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } strm_state_e;

    // Outputs are registered, the macro registers them again, and its data
    // settles on the following negedge: sample two posedges after driving.
    localparam int RD_LAT = 2;

    // The window is 2**aw words of 4 bytes; every address bit above it must
    // match the base.
    function automatic logic addr_hit(input logic [31:0] adr,
                                      input logic [31:0] base,
                                      input int          aw);
        logic [31:0] diff;
        diff = (adr ^ base) >> (aw + 2);
        return (diff == 32'd0);
    endfunction

endpackage

// File: rtl/sram_stream_fifo.sv
// Small synchronous FIFO holding port-1 read words until the sink takes them.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   push_i/push_data_i : write one word
//   pop_i          : remove the head word (ignored when empty)
//   data_o         : head word (storage is reset, so it reads 0 after reset)
//   valid_o        : FIFO not empty
//   count_o        : number of stored words, 0..DEPTH
module sram_stream_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [W-1:0]               push_data_i,
    input  logic                       pop_i,
    output logic [W-1:0]               data_o,
    output logic                       valid_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    assign pop_ok  = pop_i && (count_q != '0);
    // A push into a full FIFO is only accepted if a pop frees a slot.
    assign push_ok = push_i && ((count_q != CW'(DEPTH)) || pop_ok);

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule

// File: rtl/wb_sram_1rw1r_ctrl.sv
// Controller for a 1RW+1R OpenRAM macro.
//   Wishbone classic slave (wb_*)      -> port 0 read/write cycles
//   Streaming read engine (strm_*)     -> port 1 sequential reads into a FIFO
//   sram_*0 / sram_*1                  -> registered macro controls, macro data in
//   dbg_p0_state_o / dbg_strm_state_o  -> current FSM states for observation
// Stream handshake: a word transfers on a cycle where strm_valid and
// strm_ready are both high; strm_data/strm_valid hold until that happens,
// and strm_ready may change freely without a valid.
module wb_sram_1rw1r_ctrl
    import wb_sram_pkg::*;
#(
    parameter int          ADDR_WIDTH = 8,
    parameter int          DATA_WIDTH = 32,
    parameter int          NUM_WMASKS = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_we_i,
    input  logic [31:0]           wb_adr_i,
    input  logic [NUM_WMASKS-1:0] wb_sel_i,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    output logic                  wb_ack_o,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1,
    input  logic                  strm_start,
    input  logic [ADDR_WIDTH-1:0] strm_base,
    input  logic [ADDR_WIDTH:0]   strm_len,
    output logic [DATA_WIDTH-1:0] strm_data,
    output logic                  strm_valid,
    input  logic                  strm_ready,
    output logic                  strm_busy,
    output logic                  strm_done,
    output p0_state_e             dbg_p0_state_o,
    output strm_state_e           dbg_strm_state_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int LW = ADDR_WIDTH + 1;

    // ---------------- Port 0: Wishbone sequencer ----------------
    p0_state_e             p0_state_q, p0_state_d;
    logic                  csb0_q, csb0_d;
    logic                  web0_q, web0_d;
    logic [NUM_WMASKS-1:0] wmask0_q, wmask0_d;
    logic [ADDR_WIDTH-1:0] addr0_q, addr0_d;
    logic [DATA_WIDTH-1:0] din0_q, din0_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    logic                  ack_q, ack_d;
    logic                  abort_q, abort_d;   // cyc dropped during this access
    logic                  req_hit;

    assign req_hit = wb_cyc_i && wb_stb_i && addr_hit(wb_adr_i, BASE_ADDR, ADDR_WIDTH);

    always_comb begin
        p0_state_d = p0_state_q;
        csb0_d     = csb0_q;
        web0_d     = web0_q;
        wmask0_d   = wmask0_q;
        addr0_d    = addr0_q;
        din0_d     = din0_q;
        dat_d      = dat_q;
        abort_d    = abort_q;
        ack_d      = 1'b0;
        case (p0_state_q)
            P0_IDLE: begin
                if (req_hit) begin
                    p0_state_d = P0_ISSUE;
                    // An all-zero byte select write touches nothing, so the
                    // macro is not selected but the bus still gets its ack.
                    csb0_d   = wb_we_i && (wb_sel_i == '0);
                    web0_d   = !wb_we_i;
                    wmask0_d = wb_we_i ? wb_sel_i : '0;
                    addr0_d  = wb_adr_i[ADDR_WIDTH+1:2];
                    din0_d   = wb_dat_i;
                    abort_d  = 1'b0;
                end
            end
            P0_ISSUE: begin
                csb0_d  = 1'b1;
                web0_d  = 1'b1;
                abort_d = abort_q || !wb_cyc_i;
                if (web0_q) begin
                    p0_state_d = P0_WAIT;
                end else begin
                    p0_state_d = P0_ACK;
                    ack_d      = !abort_d;
                end
            end
            P0_WAIT: begin
                dat_d      = sram_dout0;
                abort_d    = abort_q || !wb_cyc_i;
                p0_state_d = P0_ACK;
                ack_d      = !abort_d;
            end
            P0_ACK: begin
                p0_state_d = P0_IDLE;
            end
            default: p0_state_d = P0_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            p0_state_q <= P0_IDLE;
            csb0_q     <= 1'b1;
            web0_q     <= 1'b1;
            wmask0_q   <= '0;
            addr0_q    <= '0;
            din0_q     <= '0;
            dat_q      <= '0;
            ack_q      <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            p0_state_q <= p0_state_d;
            csb0_q     <= csb0_d;
            web0_q     <= web0_d;
            wmask0_q   <= wmask0_d;
            addr0_q    <= addr0_d;
            din0_q     <= din0_d;
            dat_q      <= dat_d;
            ack_q      <= ack_d;
            abort_q    <= abort_d;
        end
    end

    assign sram_csb0   = csb0_q;
    assign sram_web0   = web0_q;
    assign sram_wmask0 = wmask0_q;
    assign sram_addr0  = addr0_q;
    assign sram_din0   = din0_q;
    assign wb_dat_o    = dat_q;
    assign wb_ack_o    = ack_q;

    // ---------------- Port 1: streaming read engine ----------------
    strm_state_e           st_q, st_d;
    logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
    logic [ADDR_WIDTH-1:0] addr1_q, addr1_d;
    logic [LW-1:0]         issue_left_q, issue_left_d;  // reads not yet issued
    logic [LW-1:0]         pop_left_q, pop_left_d;      // words not yet delivered
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    // Bit 0 marks a read being presented to the macro this cycle; the top
    // bit marks read data arriving now, which is pushed into the FIFO.
    logic [RD_LAT-1:0]     rd_pipe_q, rd_pipe_d;
    logic                  issue;
    logic                  pop;
    logic [CW-1:0]         fifo_count;
    logic [CW-1:0]         inflight;
    logic [CW:0]           credit_used;
    logic                  credit_ok;

    assign pop = strm_valid && strm_ready;

    // Every issued word owns a FIFO slot until it is popped, so counting
    // in-flight reads against free space makes overflow impossible.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) inflight = inflight + CW'(rd_pipe_q[i]);
        credit_used = {1'b0, fifo_count} + {1'b0, inflight};
        credit_ok   = (credit_used < (CW+1)'(FIFO_DEPTH));
    end

    always_comb begin
        st_d         = st_q;
        next_addr_d  = next_addr_q;
        issue_left_d = issue_left_q;
        pop_left_d   = pop_left_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        issue        = 1'b0;
        case (st_q)
            ST_IDLE: begin
                if (strm_start) begin
                    next_addr_d  = strm_base;
                    issue_left_d = strm_len;
                    pop_left_d   = strm_len;
                    if (strm_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        st_d   = ST_RUN;
                        busy_d = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if ((issue_left_q != '0) && credit_ok) begin
                    issue        = 1'b1;
                    next_addr_d  = next_addr_q + ADDR_WIDTH'(1);  // wraps at the top
                    issue_left_d = issue_left_q - LW'(1);
                end
                if (pop) begin
                    pop_left_d = pop_left_q - LW'(1);
                    if (pop_left_q == LW'(1)) begin
                        st_d   = ST_IDLE;
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end
                end
            end
            default: st_d = ST_IDLE;
        endcase
        addr1_d   = issue ? next_addr_q : addr1_q;
        rd_pipe_d = {rd_pipe_q[RD_LAT-2:0], issue};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            st_q         <= ST_IDLE;
            next_addr_q  <= '0;
            addr1_q      <= '0;
            issue_left_q <= '0;
            pop_left_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rd_pipe_q    <= '0;
        end else begin
            st_q         <= st_d;
            next_addr_q  <= next_addr_d;
            addr1_q      <= addr1_d;
            issue_left_q <= issue_left_d;
            pop_left_q   <= pop_left_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            rd_pipe_q    <= rd_pipe_d;
        end
    end

    sram_stream_fifo #(
        .W     (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i       (clk),
        .rst_ni      (resetn),
        .push_i      (rd_pipe_q[RD_LAT-1]),
        .push_data_i (sram_dout1),
        .pop_i       (pop),
        .data_o      (strm_data),
        .valid_o     (strm_valid),
        .count_o     (fifo_count)
    );

    assign sram_csb1  = !rd_pipe_q[0];
    assign sram_addr1 = addr1_q;
    assign strm_busy  = busy_q;
    assign strm_done  = done_q;

    assign dbg_p0_state_o   = p0_state_q;
    assign dbg_strm_state_o = st_q;

endmodule

// File: tb/tb_wb_sram_1rw1r_ctrl.sv
module tb_wb_sram_1rw1r_ctrl;
  import wb_sram_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [31:0] wb_adr_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_i, wb_dat_o;
  logic        wb_ack_o;
  logic        sram_csb0, sram_web0, sram_csb1;
  logic [3:0]  sram_wmask0;
  logic [7:0]  sram_addr0, sram_addr1;
  logic [31:0] sram_din0, sram_dout0, sram_dout1;
  logic        strm_start, strm_ready, strm_valid, strm_busy, strm_done;
  logic [7:0]  strm_base;
  logic [8:0]  strm_len;
  logic [31:0] strm_data;
  p0_state_e   dbg_p0_state;
  strm_state_e dbg_strm_state;

  wb_sram_1rw1r_ctrl dut (
    .clk(clk), .resetn(resetn),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0),
    .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1),
    .strm_start(strm_start), .strm_base(strm_base), .strm_len(strm_len),
    .strm_data(strm_data), .strm_valid(strm_valid), .strm_ready(strm_ready),
    .strm_busy(strm_busy), .strm_done(strm_done),
    .dbg_p0_state_o(dbg_p0_state), .dbg_strm_state_o(dbg_strm_state)
  );

  // ---------------- SRAM macro model (registered inputs, negedge data) ----------------
  logic [31:0] mem [256];
  logic        csb0_r = 1'b1, web0_r = 1'b1, csb1_r = 1'b1;
  logic [3:0]  wm0_r = '0;
  logic [7:0]  a0_r = '0, a1_r = '0;
  logic [31:0] d0_r = '0;

  always @(posedge clk) begin
    csb0_r <= sram_csb0; web0_r <= sram_web0; wm0_r <= sram_wmask0;
    a0_r <= sram_addr0; d0_r <= sram_din0;
    csb1_r <= sram_csb1; a1_r <= sram_addr1;
  end

  always @(negedge clk) begin
    if (!csb0_r) begin
      if (!web0_r) begin
        for (int b = 0; b < 4; b++)
          if (wm0_r[b]) mem[a0_r][8*b +: 8] <= d0_r[8*b +: 8];
      end else begin
        sram_dout0 <= mem[a0_r];
      end
    end
    if (!csb1_r) sram_dout1 <= mem[a1_r];
  end

  // ---------------- scoreboard ----------------
  logic [31:0] ref_mem [256];
  logic [31:0] wb_exp_q[$];
  logic [31:0] strm_exp_q[$];
  int n_checks = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                         input logic [31:0] dat, output int lat, output logic [31:0] rdat,
                         output logic csb_seen);
    @(posedge clk); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr; wb_sel_i = sel; wb_dat_i = dat;
    lat = -1; rdat = '0; csb_seen = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (!sram_csb0) csb_seen = 1'b1;
      if (wb_ack_o) begin
        lat = c; rdat = wb_dat_o;
        break;
      end
    end
    @(posedge clk); #1;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [3:0] sel,
                          input logic [31:0] dat, output logic csb_seen);
    int lat;
    logic [31:0] rd;
    logic [7:0] idx;
    idx = adr[9:2];
    for (int b = 0; b < 4; b++)
      if (sel[b]) ref_mem[idx][8*b +: 8] = dat[8*b +: 8];
    wb_xfer(1'b1, adr, sel, dat, lat, rd, csb_seen);
    check_eq("wr_ack_lat", lat, 2);
  endtask

  task automatic wb_read(input logic [31:0] adr);
    int lat;
    logic [31:0] rd;
    logic cs;
    logic [7:0] idx;
    idx = adr[9:2];
    wb_exp_q.push_back(ref_mem[idx]);
    wb_xfer(1'b0, adr, 4'h0, 32'h0, lat, rd, cs);
    check_eq("rd_ack_lat", lat, 3);
    if (wb_exp_q.size() > 0) check_eq("rd_data", rd, wb_exp_q.pop_front());
  endtask

  task automatic run_stream(input logic [7:0] base, input logic [8:0] len, input logic toggle,
                            output int done_cyc, output int done_cnt, output int issued,
                            output int popped, output int peak, output int first_pop,
                            output int last_pop, output logic busy_at_done);
    logic [7:0] a;
    for (int i = 0; i < int'(len); i++) begin
      a = base + 8'(i);
      strm_exp_q.push_back(ref_mem[a]);
    end
    done_cyc = -1; done_cnt = 0; issued = 0; popped = 0; peak = 0;
    first_pop = -1; last_pop = -1; busy_at_done = 1'b1;
    @(posedge clk); #1;
    strm_start = 1'b1; strm_base = base; strm_len = len; strm_ready = 1'b1;
    for (int c = 0; c < 48; c++) begin
      @(negedge clk);
      if (!sram_csb1) issued++;
      if (issued - popped > peak) peak = issued - popped;
      if (strm_done) begin
        done_cnt++; done_cyc = c; busy_at_done = strm_busy;
      end
      if (strm_valid) begin
        if (strm_ready) begin
          if (strm_exp_q.size() > 0) check_eq("strm_pop", strm_data, strm_exp_q.pop_front());
          popped++;
          if (first_pop < 0) first_pop = c;
          last_pop = c;
        end else if (strm_exp_q.size() > 0) begin
          check_eq("strm_hold", strm_data, strm_exp_q[0]);
        end
      end
      @(posedge clk); #1;
      strm_start = 1'b0;
      if (toggle) strm_ready = ~strm_ready;
    end
  endtask

  // ---------------- main sequence ----------------
  int dcyc, dcnt, iss, pops, pk, fp, lp;
  logic bad;
  logic cs;
  int lat;
  logic [31:0] rd;

  initial begin
    resetn = 1'b0;
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_adr_i = 0; wb_sel_i = 0; wb_dat_i = 0;
    strm_start = 0; strm_base = 0; strm_len = 0; strm_ready = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ctrl", {wb_ack_o, sram_csb0, sram_web0, sram_csb1, strm_valid, strm_busy, strm_done},
             7'b0111000);
    check_eq("rst_data", wb_dat_o | strm_data | sram_din0, 32'h0);
    @(negedge clk); resetn = 1'b1;

    // Full-word write then read back.
    wb_write(32'h3000_0010, 4'hF, 32'hDEAD_BEEF, cs);
    check_eq("wr_csb0", cs, 1'b1);
    check_eq("wr_addr0", sram_addr0, 8'd4);
    wb_read(32'h3000_0010);
    check_eq("rd_addr0", sram_addr0, 8'd4);

    // Byte-lane merge, then zero-select write leaves the word alone.
    wb_write(32'h3000_0020, 4'hF, 32'h1122_3344, cs);
    wb_write(32'h3000_0020, 4'b0010, 32'h0000_AB00, cs);
    check_eq("mask_ref", ref_mem[8], 32'h1122_AB44);
    wb_read(32'h3000_0020);
    wb_write(32'h3000_0020, 4'h0, 32'hFFFF_FFFF, cs);
    check_eq("sel0_csb0", cs, 1'b0);
    wb_read(32'h3000_0020);

    // Outside the 1 KiB window: no ack and no macro select.
    wb_xfer(1'b0, 32'h3000_0400, 4'hF, 32'h0, lat, rd, cs);
    check_eq("oow_ack", lat, -1);
    check_eq("oow_csb0", cs, 1'b0);

    // Sequential stream with the sink always ready.
    for (int i = 0; i < 8; i++) wb_write(32'h3000_0000 + 32'(4*i), 4'hF, 32'(i*3), cs);
    run_stream(8'd0, 9'd8, 1'b0, dcyc, dcnt, iss, pops, pk, fp, lp, bad);
    check_eq("s1_pops", pops, 8);
    check_eq("s1_issued", iss, 8);
    check_eq("s1_consec", lp - fp, 7);
    check_eq("s1_done_cnt", dcnt, 1);
    check_eq("s1_done_at", dcyc, lp + 1);
    check_eq("s1_busy_at_done", bad, 1'b0);
    check_eq("s1_credit", pk <= 4, 1'b1);
    check_eq("s1_left", strm_exp_q.size(), 0);

    // Wrapping stream with a toggling sink.
    wb_write(32'h3000_03F8, 4'hF, 32'hA5A5_0254, cs);
    wb_write(32'h3000_03FC, 4'hF, 32'h5A5A_0255, cs);
    run_stream(8'd254, 9'd4, 1'b1, dcyc, dcnt, iss, pops, pk, fp, lp, bad);
    check_eq("s2_pops", pops, 4);
    check_eq("s2_done_cnt", dcnt, 1);
    check_eq("s2_done_at", dcyc, lp + 1);
    check_eq("s2_busy_at_done", bad, 1'b0);
    check_eq("s2_credit", pk <= 4, 1'b1);
    check_eq("s2_left", strm_exp_q.size(), 0);

    // Reset in the middle of a stream and a port-0 read.
    @(posedge clk); #1;
    strm_start = 1'b1; strm_base = 8'd0; strm_len = 9'd8; strm_ready = 1'b0;
    @(posedge clk); #1;
    strm_start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h3000_0008;
    @(negedge clk);
    check_eq("pre_rst_busy", {strm_busy, strm_valid}, 2'b11);
    @(posedge clk); #3;
    resetn = 1'b0;
    #1;
    check_eq("mid_rst_ctrl", {wb_ack_o, sram_csb0, sram_web0, sram_csb1, strm_valid, strm_busy, strm_done},
             7'b0111000);
    check_eq("mid_rst_data", wb_dat_o | strm_data | sram_din0, 32'h0);
    check_eq("mid_rst_addr", {sram_addr0, sram_addr1, sram_wmask0}, 20'h0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (wb_ack_o) bad = 1'b1;
      if (c == 1) resetn = 1'b1;
    end
    check_eq("rst_no_ack", bad, 1'b0);
    check_eq("rst_strm_idle", {strm_busy, strm_valid}, 2'b00);

    run_stream(8'd0, 9'd0, 1'b0, dcyc, dcnt, iss, pops, pk, fp, lp, bad);
    check_eq("len0_done_at", dcyc, 1);
    check_eq("len0_done_cnt", dcnt, 1);
    check_eq("len0_issued", iss, 0);
    wb_read(32'h3000_0008);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wb_sram_1rw1r_ctrl.md
Name: wb_sram_1rw1r_ctrl

Overview:
Initiator-side controller for the 32x256 OpenRAM dual-port macro (port 0 RW, port 1 R). It is a Wishbone classic slave that turns CPU reads and writes into port-0 cycles. It also runs a port-1 streaming read engine that pushes sequential words into a valid/ready sink through a small FIFO. It sits between the user-area Wishbone bus and the SRAM macro, so the SRAM's registered-input and negedge-output timing never reaches the bus.

Parameters:
ADDR_WIDTH, 8, SRAM word-address width; depth is 2**ADDR_WIDTH.
DATA_WIDTH, 32, word width.
NUM_WMASKS, 4, byte-lane count (DATA_WIDTH/8).
BASE_ADDR, 32'h3000_0000, Wishbone byte base; bits [31:ADDR_WIDTH+2] are decoded.
FIFO_DEPTH, 4, stream FIFO entries (power of 2, >=4).

Ports:
clk  in  1  single clock; wb_clk and both SRAM clocks are driven from it.
resetn  in  1  asynchronous active-low reset.
wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  Wishbone classic controls.
wb_adr_i  in  32  byte address; word index is [ADDR_WIDTH+1:2].
wb_sel_i  in  NUM_WMASKS  byte selects.
wb_dat_i  in  DATA_WIDTH  write data.
wb_dat_o  out  DATA_WIDTH  read data.
wb_ack_o  out  1  single-cycle acknowledge.
sram_csb0, sram_web0  out  1 each  port-0 chip select / write enable (active low).
sram_wmask0  out  NUM_WMASKS  port-0 byte mask.
sram_addr0  out  ADDR_WIDTH  port-0 address.
sram_din0  out  DATA_WIDTH  port-0 write data.
sram_dout0  in  DATA_WIDTH  port-0 read data.
sram_csb1  out  1  port-1 chip select (active low).
sram_addr1  out  ADDR_WIDTH  port-1 address.
sram_dout1  in  DATA_WIDTH  port-1 read data.
strm_start  in  1  pulse; starts a stream.
strm_base  in  ADDR_WIDTH  first word address.
strm_len  in  ADDR_WIDTH+1  word count, 0..2**ADDR_WIDTH.
strm_data  out  DATA_WIDTH  stream word.
strm_valid  out  1  stream word available.
strm_ready  in  1  sink accepts the word.
strm_busy  out  1  engine active.
strm_done  out  1  one-cycle pulse on completion.

Behaviour:
- Reset (async, resetn=0):
  - Cleared to 0: wb_ack_o, wb_dat_o, sram_wmask0, sram_addr0, sram_din0, sram_addr1, strm_valid, strm_data, strm_busy, strm_done.
  - Held at 1: sram_csb0, sram_web0, sram_csb1.
  - FIFO is emptied, in-flight counters are cleared, and both FSMs go to IDLE.
  - Reset mid-transfer abandons the transfer and produces no ack. Any in-flight SRAM data is discarded.
- All SRAM outputs are registered. The macro captures them on the next posedge and its data is sampled two posedges after it is driven.
- Port-0 FSM has states IDLE, ISSUE, WAIT, ACK.
  - IDLE: takes a request when cyc&stb are high and the address decodes. It registers the SRAM outputs and sets csb0=0, web0=!we, wmask0=we?sel:0, and moves to ISSUE. If sel=0 on a write, csb0 stays 1.
  - ISSUE: deasserts csb0. A write goes to ACK. A read goes to WAIT.
  - WAIT: registers wb_dat_o<=sram_dout0 and goes to ACK.
  - ACK: holds wb_ack_o=1 for exactly one cycle, then goes to IDLE.
  - With the request first seen in cycle 0, a write acks in cycle 2 and a read acks in cycle 3.
- Address mismatch: no SRAM access and no ack; the interconnect handles the timeout. cyc dropped before ack: the FSM finishes its sequence without asserting ack.
- Stream engine states are IDLE and RUN.
  - strm_start in IDLE latches base and len. If len=0, strm_done pulses the next cycle, the engine stays in IDLE and no reads are issued. Otherwise it enters RUN with strm_busy=1.
  - strm_start while busy is ignored.
  - RUN issues one port-1 read per cycle (csb1=0, addr1=next) while fifo_count + inflight < FIFO_DEPTH and words remain.
  - Read data lands two cycles after issue and is pushed into the FIFO.
  - Address increments mod 2**ADDR_WIDTH, so the stream wraps from 255 to 0.
  - After the last word is popped, strm_done pulses and strm_busy falls in the same cycle.
- FIFO behaviour:
  - Pop on strm_valid&strm_ready.
  - A simultaneous push and pop leaves the count unchanged.
  - strm_data is the FIFO head and is stable while valid and not ready.
  - The FIFO never overflows, because issue is credit-gated.
- Port 0 and port 1 are independent. A port-0 write to the address currently being streamed gives undefined stream data for that word, and this is allowed.

Decomposition:
- Package wb_sram_pkg holds:
  - port-0 and stream FSM state enums;
  - the read-latency constant RD_LAT=2;
  - the BASE_ADDR decode helper function.
- One sub-module, sram_stream_fifo, is a parameterised synchronous FIFO with count output and async active-low reset.

Test Plan:
- Write 0xDEADBEEF to 0x3000_0010 with sel=4'hF, then read it back: ack in cycle 2 (write) and cycle 3 (read), wb_dat_o=0xDEADBEEF, sram_addr0=4.
- Write sel=4'b0010, dat=0x0000AB00 over 0x11223344, then read: returns 0x1122AB44. A write with sel=0 acks and leaves the word unchanged.
- Access 0x3000_0400 (outside the 1 KiB window): wb_ack_o stays 0 for 16 cycles and csb0 stays 1.
- Preload words 0..7 with i*3, stream base=0 len=8 with strm_ready=1: values 0,3,...,21 appear on consecutive cycles, strm_done pulses once, and strm_busy falls with it.
- Stream base=254 len=4 with strm_ready toggling 1010: words 254,255,0,1 arrive in order, fifo_count+inflight never exceeds 4, and data holds while ready=0.
- Assert resetn=0 mid-stream and mid-read: all outputs go to reset values immediately, no ack appears, and after release a new strm_start with len=0 gives strm_done the next cycle.
